mac_dot_accum: RTL and testbench
================================

Name: mac_dot_accum

Overview:
- Downstream stage of `mac`: takes the per-cycle `out` products/sums and accumulates VEC_LEN consecutive terms into one dot-product result.
- Presents each finished result on a valid/ready output port with backpressure to the consumer.
- Backpressure propagates to the producer through in_ready.
- Sits between `mac` and the result writer/consumer in the datapath.

Parameters:
- OUT_WIDTH, 4, width of each incoming term (matches `mac` OUT_WIDTH).
- VEC_LEN, 4, terms per result; legal range 1..255.
- ACC_WIDTH, 8, accumulator/result width; must be >= OUT_WIDTH.
- CNT_WIDTH, 8, term counter width; must hold VEC_LEN.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous discard of partial sum and any pending result.
- in_valid  input  1  in_data holds a valid term.
- in_ready  output  1  block accepts a term this cycle.
- in_data  input  OUT_WIDTH  term from `mac` out, unsigned.
- out_valid  output  1  out_sum/out_ovf hold a completed result.
- out_ready  input  1  consumer accepts the result this cycle.
- out_sum  output  ACC_WIDTH  dot-product result, modulo 2^ACC_WIDTH.
- out_ovf  output  1  at least one carry out of ACC_WIDTH occurred while forming this result.
- term_cnt  output  CNT_WIDTH  terms accepted into the current partial sum.

Behaviour:
- Reset (synchronous, active-high):
  - out_valid=0, out_sum=0, out_ovf=0, term_cnt=0.
  - Accumulator=0, overflow flag=0, state=ACCUM.
- Handshakes:
  - Input handshake completes when in_valid & in_ready at the clock edge.
  - Output handshake completes when out_valid & out_ready at the clock edge.
  - in_ready = !out_valid | out_ready (combinational; no in_valid→in_ready path).
- States:
  - ACCUM: out_valid=0.
  - HOLD: out_valid=1.
- ACCUM, on an accepted term:
  - acc <= acc + zero-extended in_data; ovf <= ovf | carry; term_cnt increments.
  - If it is the VEC_LEN-th term: out_sum <= acc+in_data, out_ovf <= final ovf, out_valid <= 1, acc/ovf/term_cnt <= 0, state <= HOLD.
- Latency: result is visible the cycle after the last term is accepted.
- HOLD:
  - out_sum and out_ovf stay stable until the output handshake completes.
  - On the output handshake with no term accepted: out_valid <= 0, state <= ACCUM.
  - Output handshake and input handshake in the same cycle: the result is released and the new term starts the next sum (acc=in_data, term_cnt=1). This gives full throughput.
  - If that term completes a VEC_LEN=1 vector, remain in HOLD with the new result.
- Unsigned add only; no saturation; wrap modulo 2^ACC_WIDTH with the sticky carry reported in out_ovf.
- Priority: reset > clear > handshakes.
- clear:
  - Clears acc, ovf and term_cnt, sets out_valid=0 and state=ACCUM.
  - A term presented in the clear cycle is dropped, even if in_ready=1.
- Reset mid-vector discards the partial sum; the first term after reset starts a new vector.
- VEC_LEN=1: every accepted term produces a result; out_sum = zero-extended in_data.
- in_data is never sampled when in_valid=0; X on in_data with in_valid=0 must not propagate.

Decomposition:
- Shared package mac_pkg:
  - state encoding for ACCUM/HOLD;
  - default widths (DATA_WIDTH=2, OUT_WIDTH=4, ACC_WIDTH=8);
  - localparam for minimum counter width.
- One natural sub-module, mac_acc_adder: combinational ACC_WIDTH adder returning sum and carry-out, reused by later accumulate stages.
- FSM, counter and output register stay in mac_dot_accum.

Test Plan:
- Basic vector: VEC_LEN=4, ACC_WIDTH=8, out_ready=1, terms 0x6,0x3,0xA,0xF on consecutive cycles → out_valid one cycle after the 4th term, out_sum=0x22, out_ovf=0, term_cnt returns to 0.
- Backpressure: same terms with out_ready=0 → out_valid held and out_sum=0x22 stable, in_ready=0. A 5th term presented is not accepted until out_ready=1. That cycle releases the result and accepts the term (term_cnt=1).
- Back-to-back streaming: 8 terms of 0xF with out_ready=1 → two results of 0x3C each. The second result appears exactly 4 cycles after the first, with no lost cycle.
- Overflow: ACC_WIDTH=5, four terms of 0xF → out_sum=0x1C (60 mod 32), out_ovf=1. The next vector 1,1,1,1 → out_sum=0x04, out_ovf=0.
- Clear/reset mid-vector: accept 0x5,0x7, then pulse clear while in_valid=1 with 0x9 → term_cnt=0, 0x9 dropped. Then 1,2,3,4 → out_sum=0x0A. Repeat with reset instead of clear → same result, all outputs 0 the cycle after reset.
- VEC_LEN=1: terms 0x3, 0xC with out_ready=1 → results 0x03 then 0x0C on consecutive cycles, out_valid continuously high.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the mac datapath stages.
package mac_pkg;

  // Default widths used across the mac datapath.
  localparam int unsigned MAC_DATA_WIDTH = 2;
  localparam int unsigned MAC_OUT_WIDTH  = 4;
  localparam int unsigned MAC_ACC_WIDTH  = 8;

  // Smallest term counter that can hold the largest legal VEC_LEN (255).
  localparam int unsigned MAC_CNT_MIN_WIDTH = 8;

  // Accumulate stage states: building a sum, or holding a finished result.
  typedef enum logic {
    StAccum = 1'b0,
    StHold  = 1'b1
  } acc_state_e;

endpackage

// File: rtl/mac_acc_adder.sv
// Combinational unsigned adder with carry-out, shared by accumulate stages.
module mac_acc_adder #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         carry
);

  // One extra bit captures the carry out of the top position.
  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/mac_dot_accum.sv
// Accumulates VEC_LEN consecutive mac terms into one dot-product result,
// presented on a valid/ready port with backpressure to the producer.
module mac_dot_accum
  import mac_pkg::*;
#(
  parameter int unsigned OUT_WIDTH = MAC_OUT_WIDTH,
  parameter int unsigned VEC_LEN   = 4,
  parameter int unsigned ACC_WIDTH = MAC_ACC_WIDTH,
  parameter int unsigned CNT_WIDTH = MAC_CNT_MIN_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OUT_WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic                 out_ovf,
  output logic [CNT_WIDTH-1:0] term_cnt
);

  localparam logic [CNT_WIDTH-1:0] LastCnt = CNT_WIDTH'(VEC_LEN - 1);

  acc_state_e           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0] sum_q, sum_d;
  logic                 sum_ovf_q, sum_ovf_d;

  logic                 in_fire, out_fire;
  logic [ACC_WIDTH-1:0] addend, add_sum;
  logic                 add_carry;

  assign out_valid = (state_q == StHold);
  assign in_ready  = !out_valid | out_ready;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Gate the term so in_data never reaches the adder unless it is being accepted.
  assign addend = in_fire ? ACC_WIDTH'(in_data) : '0;

  mac_acc_adder #(
    .W(ACC_WIDTH)
  ) u_adder (
    .a    (acc_q),
    .b    (addend),
    .sum  (add_sum),
    .carry(add_carry)
  );

  // Next-state: release results, accumulate terms, close a vector on the last term.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    sum_ovf_d = sum_ovf_q;

    if (clear) begin
      state_d = StAccum;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StAccum: ;
        StHold:  if (out_fire) state_d = StAccum;
        default: state_d = StAccum;
      endcase

      // In HOLD a term is only accepted alongside the release, and acc is
      // already zero there, so the same path starts the next vector.
      if (in_fire) begin
        if (cnt_q == LastCnt) begin
          sum_d     = add_sum;
          sum_ovf_d = ovf_q | add_carry;
          state_d   = StHold;
          acc_d     = '0;
          ovf_d     = 1'b0;
          cnt_d     = '0;
        end else begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_carry;
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StAccum;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      sum_q     <= '0;
      sum_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      sum_ovf_q <= sum_ovf_d;
    end
  end

  assign out_sum  = sum_q;
  assign out_ovf  = sum_ovf_q;
  assign term_cnt = cnt_q;

endmodule

// File: tb/tb_mac_dot_accum.sv
// Scoreboard bench: three configurations driven with the same stimulus,
// checked against an integer-arithmetic reference model.
module tb_mac_dot_accum;

  localparam int unsigned NDUT = 3;
  localparam int unsigned VL[NDUT] = '{4, 4, 1};
  localparam int unsigned AW[NDUT] = '{8, 5, 8};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'h0;
  logic       out_ready = 1'b0;

  logic       in_ready  [NDUT];
  logic       out_valid [NDUT];
  logic       out_ovf   [NDUT];
  logic [7:0] term_cnt  [NDUT];
  logic [7:0] sum0, sum2;
  logic [4:0] sum1;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  // Reference model state: plain integers, one vector in progress per DUT.
  int unsigned cnt_m  [NDUT];
  int unsigned part_m [NDUT];
  bit          pend_m [NDUT];
  int unsigned exp_q  [NDUT][$];   // {sum, ovf} packed as sum*2+ovf
  bit          rst_seen;

  always #5 clk = ~clk;

  mac_dot_accum #(.VEC_LEN(4)) u_dut0 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_data(in_data), .out_valid(out_valid[0]), .out_ready(out_ready), .out_sum(sum0),
    .out_ovf(out_ovf[0]), .term_cnt(term_cnt[0])
  );

  mac_dot_accum #(.VEC_LEN(4), .ACC_WIDTH(5)) u_dut1 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_data(in_data), .out_valid(out_valid[1]), .out_ready(out_ready), .out_sum(sum1),
    .out_ovf(out_ovf[1]), .term_cnt(term_cnt[1])
  );

  mac_dot_accum #(.VEC_LEN(1)) u_dut2 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready[2]),
    .in_data(in_data), .out_valid(out_valid[2]), .out_ready(out_ready), .out_sum(sum2),
    .out_ovf(out_ovf[2]), .term_cnt(term_cnt[2])
  );

  function automatic logic [31:0] dut_sum(int k);
    case (k)
      0:       return 32'(sum0);
      1:       return 32'(sum1);
      default: return 32'(sum2);
    endcase
  endfunction

  task automatic check(string name, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, k, $time, act, exp);
    end
  endtask

  // Model one clock edge from the inputs now stable on the bus.
  task automatic model_step();
    for (int k = 0; k < int'(NDUT); k++) begin
      bit exp_rdy;
      exp_rdy = !pend_m[k] || out_ready;
      check("in_ready", k, 32'(in_ready[k]), 32'(exp_rdy));
      check("out_valid", k, 32'(out_valid[k]), 32'(pend_m[k]));
      check("term_cnt", k, 32'(term_cnt[k]), cnt_m[k]);
      if (rst_seen) begin
        check("reset_sum", k, dut_sum(k), 32'd0);
        check("reset_ovf", k, 32'(out_ovf[k]), 32'd0);
      end
      if (reset || clear) begin
        cnt_m[k]  = 0;
        part_m[k] = 0;
        pend_m[k] = 1'b0;
        exp_q[k].delete();
      end else begin
        if (pend_m[k] && out_ready) pend_m[k] = 1'b0;
        if (in_valid && exp_rdy) begin
          part_m[k] += int'(in_data);
          cnt_m[k]++;
          if (cnt_m[k] == VL[k]) begin
            // Any carry out happened exactly when the true sum reached 2^W.
            exp_q[k].push_back(((part_m[k] % (1 << AW[k])) << 1)
                               | int'(part_m[k] >= (1 << AW[k])));
            pend_m[k] = 1'b1;
            cnt_m[k]  = 0;
            part_m[k] = 0;
          end
        end
      end
    end
    rst_seen = reset;
  endtask

  task automatic cycle(bit v, logic [3:0] d, bit rdy, bit clr, bit rst);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = v ? d : 4'bx;
    out_ready = rdy;
    clear     = clr;
    reset     = rst;
    @(negedge clk);
    model_step();
  endtask

  // Monitor: compare each presented result against the head of its queue.
  always @(negedge clk) begin
    if (run && !reset && !clear) begin
      for (int k = 0; k < int'(NDUT); k++) begin
        if (out_valid[k] === 1'b1) begin
          check("result_expected", k, 32'(exp_q[k].size() != 0), 32'd1);
          if (exp_q[k].size() != 0) begin
            check("out_sum", k, dut_sum(k), exp_q[k][0] >> 1);
            check("out_ovf", k, 32'(out_ovf[k]), exp_q[k][0] & 1);
            if (out_ready) void'(exp_q[k].pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] basic [4];
    basic = '{4'h6, 4'h3, 4'hA, 4'hF};
    for (int k = 0; k < int'(NDUT); k++) begin
      cnt_m[k] = 0; part_m[k] = 0; pend_m[k] = 1'b0;
    end
    rst_seen = 1'b1;
    repeat (2) @(posedge clk);
    run = 1'b1;
    cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b1);

    // Basic vector, then the same under backpressure with a 5th term waiting.
    for (int i = 0; i < 4; i++) cycle(1'b1, basic[i], 1'b1, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, basic[i], 1'b0, 1'b0, 1'b0);
    repeat (3) cycle(1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'h2, 1'b1, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);

    // Back-to-back streaming of full-scale terms.
    repeat (8) cycle(1'b1, 4'hF, 1'b1, 1'b0, 1'b0);
    repeat (4) cycle(1'b1, 4'h1, 1'b1, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);

    // Clear, then reset, mid-vector with a term presented in the same cycle.
    for (int pass = 0; pass < 2; pass++) begin
      cycle(1'b1, 4'h5, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 4'h7, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 4'h9, 1'b1, pass == 0, pass == 1);
      for (int i = 1; i <= 4; i++) cycle(1'b1, 4'(i), 1'b1, 1'b0, 1'b0);
      repeat (2) cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    end

    // Randomized phases: streaming, heavy backpressure, overflow-prone, mixed.
    for (int i = 0; i < 4000; i++) begin
      bit v, rdy, clr, rst;
      logic [3:0] d;
      d = 4'($urandom);
      case ((i / 250) % 4)
        0: begin v = 1'b1; rdy = 1'b1; end
        1: begin v = 1'($urandom); rdy = ($urandom_range(3) == 0); end
        2: begin v = 1'b1; rdy = 1'($urandom); if ($urandom_range(2) != 0) d = 4'hF; end
        default: begin v = 1'($urandom); rdy = 1'($urandom); end
      endcase
      clr = ($urandom_range(63) == 0);
      rst = ($urandom_range(127) == 0);
      cycle(v, d, rdy, clr, rst);
    end

    repeat (4) cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < int'(NDUT); k++) check("drained", k, exp_q[k].size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
